// File: rtl/onehot_index_encoder_if.sv
// Mask-job / index-beat stream bundle for onehot_index_encoder; out_count exists only with ENC_POPCNT_EN.
interface onehot_index_encoder_if #(
  parameter int WIDTH = 32
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             in_strict;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             out_err;

`ifdef ENC_POPCNT_EN
  logic [IDX_W:0]   out_count;

  modport master (
    output in_valid, in_mask, in_strict, out_ready,
    input  in_ready, out_valid, out_index, out_last, out_err, out_count
  );
  modport slave (
    input  in_valid, in_mask, in_strict, out_ready,
    output in_ready, out_valid, out_index, out_last, out_err, out_count
  );
`else
  modport master (
    output in_valid, in_mask, in_strict, out_ready,
    input  in_ready, out_valid, out_index, out_last, out_err
  );
  modport slave (
    input  in_valid, in_mask, in_strict, out_ready,
    output in_ready, out_valid, out_index, out_last, out_err
  );
`endif
endinterface

// File: rtl/onehot_index_encoder.sv
// Mask -> bit-index stream (strict one-hot or ascending iterate); first beat one cycle after accept,
// outputs held while stalled, no new job until the last beat is taken. ENC_POPCNT_EN adds out_count.
module onehot_index_encoder #(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  onehot_index_encoder_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W:0] POP_ONE = (IDX_W+1)'(1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mask_q;
  logic             valid_q;
  logic             last_q;
  logic             err_q;
  logic [IDX_W-1:0] index_q;
`ifdef ENC_POPCNT_EN
  logic [IDX_W:0]   count_q;
`endif

  logic [WIDTH-1:0] mask_d;
  logic [IDX_W:0]   in_pop;
  logic [IDX_W:0]   rem_pop;
  logic [IDX_W-1:0] in_lsb;
  logic [IDX_W-1:0] rem_lsb;
  logic             beat_done;

  function automatic logic [IDX_W:0] popcnt(input logic [WIDTH-1:0] m);
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt = popcnt + (IDX_W+1)'(m[i]);
    end
  endfunction

  function automatic logic [IDX_W-1:0] lsb_idx(input logic [WIDTH-1:0] m);
    lsb_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (m[i]) lsb_idx = IDX_W'(i);
    end
  endfunction

  // Next beat is precomputed from the mask with the current bit removed,
  // so every out_* stays a plain register.
  always_comb begin
    beat_done = valid_q && bus.out_ready;
    mask_d    = mask_q & ~(WIDTH'(1) << index_q);
    in_pop    = popcnt(bus.in_mask);
    in_lsb    = lsb_idx(bus.in_mask);
    rem_pop   = popcnt(mask_d);
    rem_lsb   = lsb_idx(mask_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      index_q <= '0;
`ifdef ENC_POPCNT_EN
      count_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q <= SCAN;
            valid_q <= 1'b1;
`ifdef ENC_POPCNT_EN
            count_q <= in_pop;
`endif
            if (bus.in_strict) begin
              mask_q  <= '0;
              last_q  <= 1'b1;
              err_q   <= (in_pop != POP_ONE);
              index_q <= (in_pop == POP_ONE) ? in_lsb : '1;
            end else if (in_pop == '0) begin
              mask_q  <= '0;
              last_q  <= 1'b1;
              err_q   <= 1'b1;
              index_q <= '1;
            end else begin
              mask_q  <= bus.in_mask;
              last_q  <= (in_pop == POP_ONE);
              err_q   <= 1'b0;
              index_q <= in_lsb;
            end
          end
        end
        SCAN: begin
          if (beat_done) begin
            if (last_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              err_q   <= 1'b0;
              mask_q  <= '0;
            end else begin
              mask_q  <= mask_d;
              index_q <= rem_lsb;
              last_q  <= (rem_pop == POP_ONE);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.out_valid = valid_q;
  assign bus.out_index = index_q;
  assign bus.out_last  = last_q;
  assign bus.out_err   = err_q;
`ifdef ENC_POPCNT_EN
  assign bus.out_count = count_q;
`endif

endmodule

// File: tb/tb_onehot_index_encoder.sv
// Bench for onehot_index_encoder: vector table, hand-written stall/reset/back-to-back sequences,
// and random jobs checked against a set-bit list model.
module tb_onehot_index_encoder;
  localparam int WIDTH = 32;
  localparam int IDX_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  onehot_index_encoder_if #(.WIDTH(WIDTH)) bus ();
  onehot_index_encoder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             err;
  } beat_t;

  typedef struct {
    logic [31:0]      mask;
    logic             strict;
    int               rmode;
    logic [IDX_W-1:0] first_idx;
    logic             first_err;
    int               n_beats;
  } vec_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t exp_q[$];
  int    exp_pop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: list every set bit, then apply the strict / empty-mask rules.
  task automatic build_exp(input logic [31:0] m, input logic s);
    beat_t b;
    int    cnt;
    exp_q.delete();
    cnt = 0;
    for (int i = 0; i < WIDTH; i++) if (m[i]) cnt++;
    exp_pop = cnt;
    if (s || cnt == 0) begin
      b.last = 1'b1;
      b.err  = !(s && cnt == 1);
      b.idx  = '1;
      if (!b.err) for (int i = 0; i < WIDTH; i++) if (m[i]) b.idx = IDX_W'(i);
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (m[i]) begin
          b.idx  = IDX_W'(i);
          b.err  = 1'b0;
          b.last = 1'b0;
          exp_q.push_back(b);
        end
      end
      exp_q[exp_q.size()-1].last = 1'b1;
    end
  endtask

  task automatic run_job(input logic [31:0] m, input logic s, input int rmode,
                         output int nb, output logic [IDX_W-1:0] fidx, output logic ferr);
    int   budget;
    logic rdy_t;
    build_exp(m, s);
    nb   = 0;
    fidx = '0;
    ferr = 1'b0;
    bus.in_mask   = m;
    bus.in_strict = s;
    bus.in_valid  = 1'b1;
    budget = 0;
    while (!bus.in_ready && budget < 50) begin
      tick;
      budget++;
    end
    if (!bus.in_ready) begin
      fail_now("accept_wait");
      bus.in_valid = 1'b0;
      return;
    end
    tick;
    bus.in_valid  = 1'b0;
    bus.in_mask   = $urandom;
    bus.in_strict = 1'($urandom);
    check("first_beat_latency", 64'(bus.out_valid), 64'(1));
    rdy_t  = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 200) begin
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       begin bus.out_ready = rdy_t; rdy_t = !rdy_t; end
        default: bus.out_ready = 1'($urandom);
      endcase
      if (!bus.out_valid) begin
        check("beat_valid", 64'(bus.out_valid), 64'(1));
        break;
      end
      check("beat_idx", 64'(bus.out_index), 64'(exp_q[0].idx));
      check("beat_last", 64'(bus.out_last), 64'(exp_q[0].last));
      check("beat_err", 64'(bus.out_err), 64'(exp_q[0].err));
      check("in_ready_busy", 64'(bus.in_ready), 64'(0));
`ifdef ENC_POPCNT_EN
      check("beat_count", 64'(bus.out_count), 64'(exp_pop));
`endif
      if (bus.out_ready) begin
        if (nb == 0) begin
          fidx = bus.out_index;
          ferr = bus.out_err;
        end
        void'(exp_q.pop_front());
        nb++;
      end
      tick;
      budget++;
    end
    if (budget >= 200) fail_now("beat_drain");
    check("no_extra_beat", 64'(bus.out_valid), 64'(0));
    check("in_ready_after_job", 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    vec_t             tbl[9];
    int               nb;
    logic [IDX_W-1:0] fidx;
    logic             ferr;
    logic [31:0]      m;

    tbl = '{
      '{32'h0000_0100, 1'b1, 0,  5'd8, 1'b0, 1},
      '{32'h0000_0104, 1'b1, 1, 5'd31, 1'b1, 1},
      '{32'h0000_0000, 1'b1, 0, 5'd31, 1'b1, 1},
      '{32'h0000_0000, 1'b0, 0, 5'd31, 1'b1, 1},
      '{32'h8000_0005, 1'b0, 1,  5'd0, 1'b0, 3},
      '{32'h8000_0000, 1'b1, 2, 5'd31, 1'b0, 1},
      '{32'h0000_0001, 1'b0, 0,  5'd0, 1'b0, 1},
      '{32'hFFFF_FFFF, 1'b1, 0, 5'd31, 1'b1, 1},
      '{32'h0000_00F0, 1'b0, 2,  5'd4, 1'b0, 4}
    };

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mask   = '0;
    bus.in_strict = 1'b0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_last", 64'(bus.out_last), 64'(0));
    check("rst_out_err", 64'(bus.out_err), 64'(0));
    check("rst_out_index", 64'(bus.out_index), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
`ifdef ENC_POPCNT_EN
    check("rst_out_count", 64'(bus.out_count), 64'(0));
`endif
    rst_n = 1'b1;
    tick;
    check("in_ready_after_rst", 64'(bus.in_ready), 64'(1));

    for (int i = 0; i < 9; i++) begin
      run_job(tbl[i].mask, tbl[i].strict, tbl[i].rmode, nb, fidx, ferr);
      check($sformatf("vec%0d_beats", i), 64'(nb), 64'(tbl[i].n_beats));
      check($sformatf("vec%0d_first_idx", i), 64'(fidx), 64'(tbl[i].first_idx));
      check($sformatf("vec%0d_first_err", i), 64'(ferr), 64'(tbl[i].first_err));
    end

    // Reset after the first beat of an iterate job drops the rest of it.
    bus.in_mask   = 32'hF0;
    bus.in_strict = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    check("rstmid_first_valid", 64'(bus.out_valid), 64'(1));
    check("rstmid_first_idx", 64'(bus.out_index), 64'(4));
    bus.out_ready = 1'b1;
    tick;
    check("rstmid_second_idx", 64'(bus.out_index), 64'(5));
    rst_n = 1'b0;
    tick;
    check("rstmid_valid_dropped", 64'(bus.out_valid), 64'(0));
    check("rstmid_in_ready_low", 64'(bus.in_ready), 64'(0));
    rst_n = 1'b1;
    tick;
    check("rstmid_stays_idle", 64'(bus.out_valid), 64'(0));
    run_job(32'h2, 1'b0, 0, nb, fidx, ferr);
    check("rstmid_new_beats", 64'(nb), 64'(1));
    check("rstmid_new_idx", 64'(fidx), 64'(1));

    // Two jobs offered back to back with in_valid held high.
    build_exp(32'h8000_0005, 1'b0);
    bus.in_mask   = 32'h8000_0005;
    bus.in_strict = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    check("b2b_ready_first", 64'(bus.in_ready), 64'(1));
    tick;
    bus.in_mask   = 32'h0000_0002;
    bus.in_strict = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("b2b_valid", 64'(bus.out_valid), 64'(1));
      check("b2b_idx", 64'(bus.out_index), 64'(exp_q[0].idx));
      check("b2b_last", 64'(bus.out_last), 64'(exp_q[0].last));
      check("b2b_in_ready_busy", 64'(bus.in_ready), 64'(0));
`ifdef ENC_POPCNT_EN
      check("b2b_count", 64'(bus.out_count), 64'(3));
`endif
      void'(exp_q.pop_front());
      tick;
    end
    check("b2b_gap_valid", 64'(bus.out_valid), 64'(0));
    check("b2b_gap_ready", 64'(bus.in_ready), 64'(1));
    tick;
    bus.in_valid = 1'b0;
    check("b2b_second_valid", 64'(bus.out_valid), 64'(1));
    check("b2b_second_idx", 64'(bus.out_index), 64'(1));
    check("b2b_second_err", 64'(bus.out_err), 64'(0));
    check("b2b_second_last", 64'(bus.out_last), 64'(1));
    tick;
    check("b2b_done", 64'(bus.out_valid), 64'(0));

    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 3))
        0:       m = 32'h0;
        1:       m = 32'h1 << $urandom_range(0, 31);
        2:       m = $urandom & $urandom & $urandom;
        default: m = $urandom;
      endcase
      run_job(m, 1'($urandom), $urandom_range(0, 2), nb, fidx, ferr);
      if ($urandom_range(0, 3) == 0) tick;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
